// File: rtl/piso_tx_if.sv
// Load and serial-side signals of the piso_tx transmitter, grouped for connection.
// Handshake: a word transfers on a rising edge where load_valid && load_ready; load_valid
// and load_data stay stable until then, and load_ready never depends on load_valid.
interface piso_tx_if #(
    parameter int WIDTH = 4
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             shift_en;
    logic             serial_out;
    logic             serial_valid;
    logic             frame_start;
    logic             busy;

    modport master (
        output load_valid, load_data, shift_en,
        input  load_ready, serial_out, serial_valid, frame_start, busy
    );

    modport slave (
        input  load_valid, load_data, shift_en,
        output load_ready, serial_out, serial_valid, frame_start, busy
    );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with a one-word holding buffer so that
// back-to-back frames leave the shifter with no idle gap.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic      clk,
    input  logic      rst_n,
    piso_tx_if.slave  bus,
    output logic      dbg_state
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;
    logic             hold_full_q, hold_full_d;

    logic active;
    logic consume;
    logic eof;
    logic accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;

        active  = (state_q == SHIFT);
        consume = active && bus.shift_en;
        eof     = consume && (cnt_q == LAST);
        accept  = bus.load_valid && !hold_full_q;

        if (consume) begin
            if (MSB_FIRST) sr_d = {sr_q[WIDTH-2:0], 1'b0};
            else           sr_d = {1'b0, sr_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
        end

        // hold_full blocks accept, so a hold transfer and a direct load never share an edge
        if (eof) begin
            cnt_d = '0;
            if (hold_full_q) begin
                sr_d        = hold_data_q;
                hold_full_d = 1'b0;
            end else begin
                state_d = IDLE;
            end
        end

        if (accept) begin
            if (!active || eof) begin
                sr_d    = bus.load_data;
                cnt_d   = '0;
                state_d = SHIFT;
            end else begin
                hold_data_d = bus.load_data;
                hold_full_d = 1'b1;
            end
        end
    end

    logic out_bit;
    assign out_bit = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

    assign bus.load_ready   = !hold_full_q;
    assign bus.serial_out   = (state_q == SHIFT) ? out_bit : 1'b0;
    assign bus.serial_valid = (state_q == SHIFT) && bus.shift_en;
    assign bus.frame_start  = bus.serial_valid && (cnt_q == '0);
    assign bus.busy         = (state_q == SHIFT) || hold_full_q;
    assign dbg_state        = state_q;
endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
Parallel-in serial-out transmitter, the send side of the team's serial shift link. It accepts parallel words on a valid/ready load port and serializes each over WIDTH consecutive enabled clocks, MSB first, so that a downstream serial-in parallel-out shift register holds the original word after the last bit. A one-word holding buffer allows back-to-back frames with no idle gap between them.

Parameters:
WIDTH, 4, bits per word (legal values 2 to 32).
MSB_FIRST, 1, bit order on the wire: 1 = MSB first (matches the team's SIPO, which shifts in at the LSB); 0 = LSB first.

Ports:
clk  input  1  single clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset; release is synchronised externally.
load_valid  input  1  load_data is valid this cycle.
load_data  input  WIDTH  word to transmit.
load_ready  output  1  holding buffer is empty; a word is accepted on a rising edge where load_valid && load_ready.
shift_en  input  1  bit-advance enable (baud tick); when low, the frame stalls.
serial_out  output  1  current serial bit.
serial_valid  output  1  serial_out is a live bit that is consumed on this edge.
frame_start  output  1  serial_valid is high and the first bit of a frame is on serial_out.
busy  output  1  shifter active or holding buffer full.

Behaviour:
- State:
  - shift register sr[WIDTH-1:0]
  - bit counter cnt, width clog2(WIDTH), range 0..WIDTH-1
  - active flag
  - hold_data[WIDTH-1:0] and hold_full
  - Two states: IDLE (active=0) and SHIFT (active=1).
- Reset (rst_n low, asynchronous): sr=0, cnt=0, active=0, hold_data=0, hold_full=0. Any in-flight frame and any held word are discarded.
- Reset values of outputs: load_ready=1, serial_out=0, serial_valid=0, frame_start=0, busy=0.
- Outputs are combinational from registers and shift_en only; there is no combinational path from load_valid or load_data to any output.
  - load_ready = !hold_full
  - serial_out = active ? (MSB_FIRST ? sr[WIDTH-1] : sr[0]) : 0
  - serial_valid = active && shift_en
  - frame_start = serial_valid && cnt==0
  - busy = active || hold_full
- A bit is consumed on every edge where serial_valid is high.
  - On that edge: sr shifts toward the output end with 0 filled in, and cnt increments.
  - When cnt==WIDTH-1 the bit is the last one (end-of-frame).
- Accept rules, for an accept occurring on an edge:
  - Shifter is IDLE, or end-of-frame happens on the same edge: the word loads directly into sr, cnt=0, active=1, and hold is untouched.
  - Otherwise: the word goes to hold_data and hold_full=1.
- End-of-frame without a simultaneous direct load:
  - If hold_full: sr<=hold_data, cnt=0, active stays 1, hold_full=0 (seamless next frame).
  - Else: active=0 (IDLE).
- Simultaneous hold_full and end-of-frame: hold moves to the shifter. load_ready is low on that edge, so no accept can collide. load_ready rises the following cycle.
- Latency: a word accepted at edge N while IDLE presents its first bit in cycle N+1. Its last bit is consumed at the (WIDTH)th subsequent enabled edge.
- Stall (shift_en low):
  - sr, cnt and serial_out are frozen; serial_valid and frame_start are low.
  - Loads into the holding buffer still occur.
- Throughput: one bit per enabled cycle, with zero gap cycles between frames when the hold buffer is refilled before end-of-frame.
- load_data is sampled only on the accept edge. Changes outside that edge have no effect.

Test Plan:
- Single frame: WIDTH=4, reset, then load 4'b1011 with shift_en=1.
  - Required: serial_out 1,0,1,1 over 4 cycles with serial_valid high; frame_start high in the first cycle only; then IDLE.
  - Required: a SIPO fed by serial_out/clk (gated by serial_valid) holds parallel_out=4'hB one cycle after the last bit.
- Back-to-back: load 4'hA, then 4'h5 one cycle later.
  - Required: 8 contiguous valid bits 1,0,1,0,0,1,0,1; frame_start at bits 0 and 4.
  - Required: load_ready low from the second accept until the hold-to-shifter transfer at end of the first frame.
- Backpressure: hold load_valid high with 4'h3, 4'hC, 4'h9 queued.
  - Required: a third accept never occurs while hold_full=1; all three words appear in order with no loss or duplication.
- Stall: during frame 4'b1001, drop shift_en for 3 cycles after bit 1.
  - Required: serial_out frozen at 0, serial_valid=0 during the stall; the remaining bits 0,1 resume; total of 4 valid bits.
- Reset mid-frame: assert rst_n low after bit 2 of 4'hF with 4'h6 held.
  - Required: outputs go immediately to their reset values and load_ready=1; after release, a new load of 4'h2 transmits 0,0,1,0 cleanly.
- LSB-first variant: MSB_FIRST=0, load 4'b0001.
  - Required: serial_out sequence 1,0,0,0.
